// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter snooping the store bus, with a TX FIFO and a STATUS word.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ram_waddr,
    input  logic [31:0] ram_wdata,
    input  logic        ram_wreg,
    input  logic [31:0] raddr,
    output logic [31:0] rdata_o,
    output logic        sel_o,
    output logic        tx,
    output logic        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [29:0]   TXD_WORD  = BASE_ADDR[31:2];
    localparam logic [29:0]   STAT_WORD = BASE_ADDR[31:2] + 30'd1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic [7:0]      fifo_mem [2**PW];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf;
    logic            full;
    logic            empty;
    logic            baud_done;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            ovf_clr;
    logic            sel_txd;
    logic            sel_stat;
    logic [31:0]     status;
`ifdef UART_PARITY_EN
    logic            parity;
`endif

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign baud_done = (baud == '0);
    assign push_req  = ram_wreg && (ram_waddr[31:2] == TXD_WORD);
    assign push      = push_req && !full;
    assign ovf_clr   = ram_wreg && (ram_waddr[31:2] == STAT_WORD) && ram_wdata[0];
    // The FSM pops when leaving IDLE or when a STOP period ends with data waiting
    assign pop       = !empty && ((state == S_IDLE) || ((state == S_STOP) && baud_done));
    assign busy      = (state != S_IDLE) || !empty;

    assign sel_txd  = (raddr[31:2] == TXD_WORD);
    assign sel_stat = (raddr[31:2] == STAT_WORD);
    assign sel_o    = sel_txd || sel_stat;
    assign status   = {23'd0, 5'(count), ovf, (state != S_IDLE), empty, full};
    assign rdata_o  = sel_stat ? status : 32'd0;

    logic unused_bits;
    assign unused_bits = ^{ram_wdata[31:8], ram_waddr[1:0], raddr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full) ovf <= 1'b1;
            else if (ovf_clr)     ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_wdata[7:0];
    end

    // Shift register holds the byte in flight; tx always presents shreg[0] of the current bit
    always_ff @(posedge clk) begin
        if (pop) begin
            shreg <= fifo_mem[rd_ptr];
`ifdef UART_PARITY_EN
            parity <= ^fifo_mem[rd_ptr];
`endif
        end else if ((state == S_DATA) && baud_done && (bit_idx != 3'd7)) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx    <= 1'b0;
                        baud  <= BAUD_LOAD;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        tx      <= shreg[0];
                        bit_idx <= 3'd0;
                        baud    <= BAUD_LOAD;
                        state   <= S_DATA;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx    <= parity;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        tx    <= 1'b1;
                        baud  <= BAUD_LOAD;
                        state <= S_STOP;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            tx    <= 1'b0;
                            baud  <= BAUD_LOAD;
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio at CLK_DIV=4, FIFO_DEPTH=16: stimulus queues expected bytes,
// a line monitor captures each serial frame and compares it against the queued byte.
module tb_uart_tx_mmio;

    localparam int CLK_DIV = 4;
`ifdef UART_PARITY_EN
    localparam int FL = 44;
`else
    localparam int FL = 40;
`endif
    localparam logic [31:0] TXD  = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic        ram_wreg;
    logic [31:0] raddr;
    logic [31:0] rdata_o;
    logic        sel_o;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] expq[$];
    int starts[$];

    uart_tx_mmio #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(16), .BASE_ADDR(32'h1000_0000)) dut (
        .clk(clk), .rst(rst), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_wreg(ram_wreg), .raddr(raddr), .rdata_o(rdata_o), .sel_o(sel_o),
        .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [FL-1:0] exp_frame(input logic [7:0] b);
        logic [FL-1:0] f;
        f = '1;
        for (int i = 0; i < 4; i++) f[i] = 1'b0;
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < 4; i++) f[4 + 4*j + i] = b[j];
`ifdef UART_PARITY_EN
        for (int i = 0; i < 4; i++) f[36 + i] = ^b;
`endif
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Line monitor: one sample per cycle on the falling edge, aborted by reset
    initial begin
        logic [FL-1:0] frame;
        logic [7:0]    b;
        int            n;
        bit            collecting;
        collecting = 0;
        n = 0;
        frame = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                collecting = 0;
            end else if (!collecting) begin
                if (tx === 1'b0) begin
                    collecting = 1;
                    frame = '1;
                    frame[0] = 1'b0;
                    n = 1;
                    starts.push_back(cyc);
                end
            end else begin
                frame[n] = tx;
                n++;
                if (n == FL) begin
                    collecting = 0;
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected actual=%h expected=none", frame);
                    end else begin
                        b = expq.pop_front();
                        if (frame !== exp_frame(b)) begin
                            errors++;
                            $display("FAIL frame byte=%h actual=%h expected=%h", b, frame, exp_frame(b));
                        end
                    end
                end
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        ram_waddr = a;
        ram_wdata = d;
        ram_wreg  = 1'b1;
        @(posedge clk);
        #1;
        ram_wreg  = 1'b0;
        ram_waddr = 32'h0;
    endtask

    task automatic read_at(input logic [31:0] a, output logic [31:0] d, output logic s);
        raddr = a;
        @(negedge clk);
        d = rdata_o;
        s = sel_o;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        s;
        int          nb;
        int          s0;
        int          w;

        rst = 1'b1;
        ram_waddr = 32'h0;
        ram_wdata = 32'h0;
        ram_wreg = 1'b0;
        raddr = STAT;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_status", rdata_o, 32'h0000_0002);
        check("reset_sel", {31'd0, sel_o}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single byte 0x55: tx falls one cycle after the push edge, busy spans pop latency + frame
        expq.push_back(8'h55);
        store(TXD, 32'h55);
        nb = 0;
        w = 0;
        do begin
            @(negedge clk);
            if (w == 0) check("first_tx_still_high", {31'd0, tx}, 32'd1);
            if (w == 0) check("first_busy", {31'd0, busy}, 32'd1);
            if (w == 1) check("first_tx_fall", {31'd0, tx}, 32'd0);
            if (busy) nb++;
            w++;
        end while (busy && w < 500);
        check("busy_cycles", nb, FL + 1);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;

        // Two queued bytes: second START immediately after first STOP
        s0 = starts.size();
        expq.push_back(8'hA0);
        expq.push_back(8'h0F);
        store(TXD, 32'hA0);
        store(TXD, 32'h0F);
        w = 0;
        while (starts.size() < s0 + 2 && w < 500) begin
            @(posedge clk);
            w++;
        end
        check("b2b_two_starts", starts.size() >= s0 + 2, 32'd1);
        if (starts.size() >= s0 + 2)
            check("b2b_gap", starts[s0 + 1] - starts[s0], FL);
        wait_idle(500);

        // STATUS with 3 queued and FSM active
        expq.push_back(8'h11);
        expq.push_back(8'h22);
        expq.push_back(8'h33);
        expq.push_back(8'h44);
        store(TXD, 32'h11);
        @(posedge clk);
        #1;
        store(TXD, 32'h22);
        store(TXD, 32'h33);
        store(TXD, 32'h44);
        read_at(STAT, d, s);
        check("stat3_sel", {31'd0, s}, 32'd1);
        check("stat3_data", d, 32'h0000_0034);
        read_at(STAT + 32'd3, d, s);
        check("stat3_lowbits_ignored", d, 32'h0000_0034);
        read_at(TXD, d, s);
        check("txdata_read_sel", {31'd0, s}, 32'd1);
        check("txdata_read_zero", d, 32'h0);
        read_at(32'h2000_0000, d, s);
        check("miss_sel", {31'd0, s}, 32'd0);
        check("miss_data", d, 32'h0);
        raddr = STAT;
        wait_idle(1000);

        // Overflow: 17 stores while a frame is in flight, the 17th is dropped
        expq.push_back(8'h80);
        store(TXD, 32'h80);
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expq.push_back(8'(8'h60 + i));
            store(TXD, 32'h60 + i);
        end
        read_at(STAT, d, s);
        check("ovf_status", d, 32'h0000_010D);
        check("ovf_bit", {31'd0, d[3]}, 32'd1);
        check("full_bit", {31'd0, d[0]}, 32'd1);
        store(STAT, 32'h1);
        read_at(STAT, d, s);
        check("ovf_cleared", d, 32'h0000_0105);
        wait_idle(17 * FL + 200);
        check("ovf_drain_queue", expq.size(), 32'd0);

        // Reset during the third data bit aborts the frame and flushes the FIFO
        store(TXD, 32'h5A);
        store(TXD, 32'hFF);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        raddr = STAT;
        @(negedge clk);
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_status", rdata_o, 32'h0000_0002);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        expq.push_back(8'hC3);
        store(TXD, 32'hC3);
        wait_idle(500);

`ifdef UART_PARITY_EN
        // 0x07 has odd weight, so the even-parity bit is 1 and the frame is 44 cycles
        expq.push_back(8'h07);
        store(TXD, 32'h07);
        nb = 0;
        w = 0;
        do begin
            @(negedge clk);
            if (w == 38) check("parity_bit", {31'd0, tx}, 32'd1);
            if (busy) nb++;
            w++;
        end while (busy && w < 500);
        check("parity_busy_cycles", nb, 45);
        @(posedge clk);
        #1;
`endif

        repeat (5) @(posedge clk);
        check("final_queue_empty", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's data-memory port, downstream of the `riscv` top alongside the data RAM. It snoops the store bus (`ram_waddr`/`ram_wdata`/`ram_wreg`) and pushes bytes written to its TXDATA address into a FIFO. A baud-rate FSM shifts each byte out serially, 8N1. A status word is returned combinationally on the load address bus (`raddr`) so the top can mux it into `rdata`.

## Interface
Parameters:
- `CLK_DIV`, default 868: clock cycles per bit; legal range ≥2.
- `FIFO_DEPTH`, default 16: TX FIFO entries; must be a power of 2, ≤16.
- `BASE_ADDR`, default 32'h1000_0000: word-aligned base address. TXDATA is at `BASE`+0, STATUS at `BASE`+4.

Ports:
- `clk` in 1: single clock; every register uses the rising edge.
- `rst` in 1: **synchronous, active-high reset.**
- `ram_waddr` in 32: store address from the MEM stage.
- `ram_wdata` in 32: store data.
- `ram_wreg` in 1: store strobe, valid for one cycle.
- `raddr` in 32: load address from the MEM stage.
- `rdata_o` out 32: register read data, combinational.
- `sel_o` out 1: `raddr` hits TXDATA or STATUS, combinational.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: FSM not IDLE or FIFO not empty.

## Operation
- Address match: compare `addr[31:2]` against `(BASE_ADDR>>2)` for TXDATA and `(BASE_ADDR>>2)+1` for STATUS. Bits [1:0] are ignored.
- Push: `ram_wreg`=1 and `ram_waddr` hits TXDATA → `ram_wdata[7:0]` enters the FIFO at the clock edge.
  - Full is evaluated before the edge. A push while full is dropped and sets sticky `ovf`, even if a pop happens in the same cycle.
- STATUS write with `ram_wdata[0]`=1 clears `ovf`.
  - If a dropped push and the clear land on the same edge, this is impossible: they are different addresses in the same cycle.
- Stores to any other address are ignored.
- STATUS read layout:
  - [0] full
  - [1] empty
  - [2] FSM not IDLE
  - [3] `ovf`
  - [8:4] FIFO count (0..`FIFO_DEPTH`)
  - all other bits 0
- TXDATA reads return 0. When `sel_o`=0, `rdata_o`=0.
- FIFO: circular buffer with read/write pointers of log2(`FIFO_DEPTH`) bits that wrap modulo depth, plus a count register of log2+1 bits.
  - Simultaneous push (not full) and pop: count is unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when configured).
  - IDLE: if FIFO not empty → pop into `shreg`, `tx`←0, go to START.
  - START: after `CLK_DIV` cycles → `tx`←`shreg[0]`, bit index 0, go to DATA.
  - DATA: every `CLK_DIV` cycles, shift right and increment the bit index. After bit 7's period → `tx`←1, go to STOP.
  - STOP: after `CLK_DIV` cycles:
    - if FIFO not empty → pop, `tx`←0, go to START, with no idle gap;
    - else go to IDLE.
- Baud counter: loads `CLK_DIV`-1 on every state/bit transition and decrements to 0. Expiry is at count 0.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, state IDLE, FIFO empty, count 0, pointers 0, `ovf`=0, baud counter 0;
  - `rdata_o`/`sel_o` follow `raddr` combinationally.
- Latency: a push at edge k makes `busy`=1 after edge k. The pop happens, and `tx` falls, after edge k+1.
- Each bit holds exactly `CLK_DIV` cycles. A frame is 10·`CLK_DIV` cycles (11·`CLK_DIV` with parity).
- Back-to-back frames have zero idle cycles between STOP and the next START.
- Reset mid-frame: at the reset edge, `tx`→1, the FIFO is flushed, and the frame is aborted. The next push starts a clean frame.
- STATUS reads reflect register state before the current edge. A push in the same cycle is not yet visible.

## Configuration
- `UART_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - `tx` = XOR of the 8 data bits (even parity), held for `CLK_DIV` cycles.
- `UART_PARITY_EN` undefined: 8N1 only, and the PARITY state and its logic are absent.

## Test plan
- Reset, then `CLK_DIV`=4, store 0x55 to 0x1000_0000:
  - `tx` falls one cycle after the push edge;
  - then holds 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles;
  - `busy` drops after 40 cycles.
- Store 17 bytes back-to-back with `FIFO_DEPTH`=16 while a frame is in flight:
  - the byte landing when full is dropped;
  - STATUS reads [3]=1 and [0]=1;
  - a store of 1 to 0x1000_0004 clears [3].
- Two queued bytes 0xA0, 0x0F: the second START begins on the cycle immediately after the first STOP period, and both frames decode correctly.
- Load `raddr`=0x1000_0004 with 3 queued and FSM active:
  - `sel_o`=1, `rdata_o`=0x0000_0034;
  - `raddr`=0x2000_0000 gives `sel_o`=0, `rdata_o`=0.
- Assert `rst` during the DATA state of the third bit: `tx`=1 after the edge, STATUS=0x0000_0002, and the next push transmits a correct frame.
- With `UART_PARITY_EN`, 0x07 → parity bit 1 and frame length 44 cycles at `CLK_DIV`=4.
